// File: rtl/sdram_arbiter_if.sv
// Command/status port between the arbiter and the SDRAM controller,
// plus the data-path owner select that travels alongside it.
interface sdram_arbiter_if;
   logic        sd_cmd_valid;
   logic        sd_cmd_ready;
   logic [24:0] sd_start_addr;
   logic [24:0] sd_length;
   logic        sd_busy;
   logic [1:0]  sd_sel;

   modport master (
      output sd_cmd_valid, sd_start_addr, sd_length, sd_sel,
      input  sd_cmd_ready, sd_busy
   );

   modport slave (
      input  sd_cmd_valid, sd_start_addr, sd_length, sd_sel,
      output sd_cmd_ready, sd_busy
   );
endinterface

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller transfer port between
// NUM_REQ requesters; tracks each transfer via sd_busy and reports done/err.
module sdram_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int TIMEOUT = 1024
) (
   input  logic                   ref_clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [25*NUM_REQ-1:0]  req_addr,
   input  logic [25*NUM_REQ-1:0]  req_len,
   output logic [NUM_REQ-1:0]     granted,
   output logic [NUM_REQ-1:0]     done,
   output logic [NUM_REQ-1:0]     err,
   sdram_arbiter_if.master        sd,
   output logic                   arb_busy
);
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, XFER, RELEASE} state_t;

   state_t             state_reg;
   logic [1:0]         rr_reg;
   logic [CW-1:0]      tmo_reg;
   logic [24:0]        addr_arr [NUM_REQ];
   logic [24:0]        len_arr  [NUM_REQ];
   logic               win_found;
   logic [1:0]         win_idx;
   logic [1:0]         cand_idx;
   int                 cand;
   logic [NUM_REQ-1:0] win_onehot;
   logic [NUM_REQ-1:0] owner_onehot;
   logic               tmo_hit;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi] = req_addr[25*gi +: 25];
      assign len_arr[gi]  = req_len[25*gi +: 25];
   end

   // First requesting index at or after the rr pointer, wrapping around.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = 0;
      cand_idx  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = int'(rr_reg) + k;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         cand_idx = 2'(cand);
         if (!win_found && req[cand_idx]) begin
            win_found = 1'b1;
            win_idx   = cand_idx;
         end
      end
   end

   assign win_onehot   = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
   assign owner_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << sd.sd_sel;
   assign tmo_hit      = (tmo_reg >= CW'(TIMEOUT - 1));

   always_ff @(posedge ref_clk) begin
      if (rst) begin
         state_reg        <= IDLE;
         rr_reg           <= '0;
         tmo_reg          <= '0;
         granted          <= '0;
         done             <= '0;
         err              <= '0;
         arb_busy         <= 1'b0;
         sd.sd_cmd_valid  <= 1'b0;
         sd.sd_start_addr <= '0;
         sd.sd_length     <= '0;
         sd.sd_sel        <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (win_found && !sd.sd_busy) begin
                  sd.sd_start_addr <= addr_arr[win_idx];
                  sd.sd_length     <= len_arr[win_idx];
                  sd.sd_sel        <= win_idx;
                  arb_busy         <= 1'b1;
                  if (len_arr[win_idx] == '0) begin
                     err       <= win_onehot;
                     state_reg <= RELEASE;
                  end else begin
                     granted         <= win_onehot;
                     sd.sd_cmd_valid <= 1'b1;
                     tmo_reg         <= '0;
                     state_reg       <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               // Accept wins over a timeout landing in the same cycle.
               if (sd.sd_cmd_ready) begin
                  sd.sd_cmd_valid <= 1'b0;
                  tmo_reg         <= tmo_reg + 1'b1;
                  state_reg       <= sd.sd_busy ? XFER : WAIT_BUSY;
               end else if (tmo_hit) begin
                  sd.sd_cmd_valid <= 1'b0;
                  granted         <= '0;
                  err             <= owner_onehot;
                  state_reg       <= RELEASE;
               end else begin
                  tmo_reg <= tmo_reg + 1'b1;
               end
            end
            WAIT_BUSY: begin
               if (sd.sd_busy) begin
                  state_reg <= XFER;
               end else if (tmo_hit) begin
                  granted   <= '0;
                  err       <= owner_onehot;
                  state_reg <= RELEASE;
               end else begin
                  tmo_reg <= tmo_reg + 1'b1;
               end
            end
            XFER: begin
               if (!sd.sd_busy) begin
                  granted   <= '0;
                  done      <= owner_onehot;
                  state_reg <= RELEASE;
               end
            end
            RELEASE: begin
               done      <= '0;
               err       <= '0;
               granted   <= '0;
               arb_busy  <= 1'b0;
               rr_reg    <= (sd.sd_sel == 2'(NUM_REQ - 1)) ? 2'd0 : sd.sd_sel + 2'd1;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: stimulus pushes expected grants and
// completions into queues, a monitor pops and compares when the DUT shows them.
module tb_sdram_arbiter;
   localparam int NUM_REQ = 3;
   localparam int TIMEOUT = 20;

   logic                  ref_clk;
   logic                  rst;
   logic [NUM_REQ-1:0]    req;
   logic [25*NUM_REQ-1:0] req_addr;
   logic [25*NUM_REQ-1:0] req_len;
   logic [NUM_REQ-1:0]    granted;
   logic [NUM_REQ-1:0]    done;
   logic [NUM_REQ-1:0]    err;
   logic                  arb_busy;

   sdram_arbiter_if sd ();

   sdram_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
      .ref_clk  (ref_clk),
      .rst      (rst),
      .req      (req),
      .req_addr (req_addr),
      .req_len  (req_len),
      .granted  (granted),
      .done     (done),
      .err      (err),
      .sd       (sd.master),
      .arb_busy (arb_busy)
   );

   initial ref_clk = 1'b0;
   always #5 ref_clk = ~ref_clk;

   int n_vec  = 0;
   int n_miss = 0;

   // Grant record: {granted, sd_sel, addr, len, cmd_valid}
   logic [63:0] grant_q [$];
   // Completion record: {done, err}
   logic [5:0]  comp_q  [$];

   logic [24:0] addr_v [NUM_REQ];
   logic [24:0] len_v  [NUM_REQ];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic load_vectors();
      for (int i = 0; i < NUM_REQ; i++) begin
         req_addr[25*i +: 25] = addr_v[i];
         req_len[25*i +: 25]  = len_v[i];
      end
   endtask

   task automatic expect_grant(input int idx);
      logic [2:0] oh;
      oh = 3'b001 << idx;
      grant_q.push_back({8'd0, oh, 2'(idx), addr_v[idx], len_v[idx], 1'b1});
   endtask

   task automatic expect_done(input int idx);
      logic [2:0] oh;
      oh = 3'b001 << idx;
      comp_q.push_back({oh, 3'b000});
   endtask

   task automatic expect_err(input int idx);
      logic [2:0] oh;
      oh = 3'b001 << idx;
      comp_q.push_back({3'b000, oh});
   endtask

   // Present a request for one cycle: the arbiter samples it in IDLE only.
   task automatic pulse_req(input logic [NUM_REQ-1:0] mask);
      req = mask;
      @(negedge ref_clk);
      req = '0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      do begin
         @(negedge ref_clk);
         t++;
      end while (arb_busy && t < 500);
      if (arb_busy) check("idle_timeout", 64'(arb_busy), 64'd0);
   endtask

   // SDRAM controller model: accept the pending command, then stay busy.
   task automatic serve(input int busy_len);
      int t;
      t = 0;
      while (!sd.sd_cmd_valid && t < 200) begin
         @(negedge ref_clk);
         t++;
      end
      if (!sd.sd_cmd_valid) check("serve_timeout", 64'(sd.sd_cmd_valid), 64'd1);
      sd.sd_cmd_ready = 1'b1;
      @(negedge ref_clk);
      sd.sd_cmd_ready = 1'b0;
      sd.sd_busy      = 1'b1;
      repeat (busy_len) @(negedge ref_clk);
      sd.sd_busy = 1'b0;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      repeat (2) @(negedge ref_clk);
      rst = 1'b0;
   endtask

   function automatic logic [63:0] all_outputs();
      return {granted, done, err, sd.sd_cmd_valid, sd.sd_start_addr, sd.sd_length, sd.sd_sel, arb_busy};
   endfunction

   // Monitor: compares grant edges and completion pulses against the queues.
   logic [NUM_REQ-1:0] prev_granted = '0;
   initial begin
      forever begin
         @(negedge ref_clk);
         if (!rst) begin
            check("onehot_excl", {62'd0, $onehot0(granted), (done & err) == '0}, 64'd3);
            if (granted != '0 && prev_granted == '0) begin
               if (grant_q.size() == 0)
                  check("unexpected_grant", {8'd0, granted, sd.sd_sel, sd.sd_start_addr, sd.sd_length, sd.sd_cmd_valid}, 64'd0);
               else
                  check("grant", {8'd0, granted, sd.sd_sel, sd.sd_start_addr, sd.sd_length, sd.sd_cmd_valid}, grant_q.pop_front());
            end
            if (sd.sd_cmd_valid && granted == '0)
               check("valid_without_grant", 64'(sd.sd_cmd_valid), 64'd0);
            if ((done | err) != '0) begin
               if (comp_q.size() == 0)
                  check("unexpected_completion", {58'd0, done, err}, 64'd0);
               else
                  check("completion", {58'd0, done, err}, {58'd0, comp_q.pop_front()});
            end
         end
         prev_granted = rst ? '0 : granted;
      end
   end

   initial begin
      int c;
      rst = 1'b1;
      req = '0;
      req_addr = '0;
      req_len = '0;
      sd.sd_cmd_ready = 1'b0;
      sd.sd_busy = 1'b0;
      addr_v = '{25'h400, 25'h1_2345, 25'h0AB_CDEF};
      len_v  = '{25'd200, 25'd33, 25'd7};
      load_vectors();
      apply_reset();
      check("reset_state", all_outputs(), 64'd0);

      // Single requester, busy for 10 cycles.
      expect_grant(0);
      expect_done(0);
      pulse_req(3'b001);
      check("t1_grant_latency", {granted, sd.sd_cmd_valid}, {3'b001, 1'b1});
      serve(10);
      wait_idle();

      // All three from reset: order 0,1,2,0.
      apply_reset();
      expect_grant(0); expect_done(0);
      expect_grant(1); expect_done(1);
      expect_grant(2); expect_done(2);
      expect_grant(0); expect_done(0);
      req = 3'b111;
      for (int i = 0; i < 4; i++) serve(4);
      req = '0;
      wait_idle();

      // Zero length on requester 1 (rr pointer is 1 here).
      len_v[1] = 25'd0;
      load_vectors();
      expect_err(1);
      pulse_req(3'b010);
      wait_idle();
      // rr pointer must now be 2.
      len_v[1] = 25'd33;
      load_vectors();
      expect_grant(2); expect_done(2);
      pulse_req(3'b111);
      serve(3);
      wait_idle();

      // Command never accepted: err after TIMEOUT cycles in ISSUE.
      len_v[0] = 25'd5;
      load_vectors();
      expect_grant(0); expect_err(0);
      pulse_req(3'b001);
      c = 0;
      while (err == '0 && c < 200) begin
         @(negedge ref_clk);
         c++;
      end
      check("timeout_cycles", 64'(c), 64'(TIMEOUT));
      check("timeout_valid_drop", {granted, sd.sd_cmd_valid}, 4'b0000);
      wait_idle();

      // Controller busy while idle holds off the grant.
      sd.sd_busy = 1'b1;
      req = 3'b100;
      repeat (5) @(negedge ref_clk);
      check("busy_holdoff", {granted, sd.sd_cmd_valid}, 4'b0000);
      expect_grant(2); expect_done(2);
      sd.sd_busy = 1'b0;
      @(negedge ref_clk);
      req = '0;
      check("busy_release_grant", {granted, sd.sd_cmd_valid}, {3'b100, 1'b1});
      serve(3);
      wait_idle();

      // Reset during XFER aborts silently; next grant goes to 0.
      expect_grant(1);
      pulse_req(3'b010);
      sd.sd_cmd_ready = 1'b1;
      @(negedge ref_clk);
      sd.sd_cmd_ready = 1'b0;
      sd.sd_busy = 1'b1;
      repeat (3) @(negedge ref_clk);
      rst = 1'b1;
      @(negedge ref_clk);
      check("reset_mid_xfer", all_outputs(), 64'd0);
      rst = 1'b0;
      sd.sd_busy = 1'b0;
      expect_grant(0); expect_done(0);
      pulse_req(3'b011);
      serve(2);
      wait_idle();

      repeat (4) @(negedge ref_clk);
      check("grant_q_drained", 64'(grant_q.size()), 64'd0);
      check("comp_q_drained", 64'(comp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end
endmodule
